// File: rtl/fifo_rr_sched_if.sv
// Handshake bundle between fifo_rr_sched and its FIFO controllers / consumer.
// The ch_weight field exists only when FIFO_RR_SCHED_WEIGHT_EN is defined.
interface fifo_rr_sched_if #(
  parameter int NCH   = 4,
  parameter int CHBIT = 2
`ifdef FIFO_RR_SCHED_WEIGHT_EN
  ,
  parameter int WBIT  = 8
`endif
);
  logic             enable;
  logic [NCH-1:0]   ch_notempty;
  logic             out_ready;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
  logic [NCH*WBIT-1:0] ch_weight;
`endif
  logic [NCH-1:0]   ch_fiford;
  logic [CHBIT-1:0] sel;
  logic             rdvalid;
  logic [CHBIT-1:0] rdsel;
  logic             busy;

`ifdef FIFO_RR_SCHED_WEIGHT_EN
  modport master (input enable, ch_notempty, out_ready, ch_weight,
                  output ch_fiford, sel, rdvalid, rdsel, busy);
  modport slave  (output enable, ch_notempty, out_ready, ch_weight,
                  input ch_fiford, sel, rdvalid, rdsel, busy);
`else
  modport master (input enable, ch_notempty, out_ready,
                  output ch_fiford, sel, rdvalid, rdsel, busy);
  modport slave  (output enable, ch_notempty, out_ready,
                  input ch_fiford, sel, rdvalid, rdsel, busy);
`endif
endinterface

// File: rtl/fifo_rr_sched.sv
// Round-robin burst read scheduler draining NCH FIFO channels into one port.
// Define FIFO_RR_SCHED_WEIGHT_EN for per-channel burst lengths from ch_weight.
module fifo_rr_sched #(
  parameter int NCH   = 4,
  parameter int CHBIT = 2,
  parameter int BURST = 4
`ifdef FIFO_RR_SCHED_WEIGHT_EN
  ,
  parameter int WBIT  = 8
`endif
) (
  input logic             clk,
  input logic             rst,
  fifo_rr_sched_if.master bus
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_q, state_d;
  logic [CHBIT-1:0] sel_q, sel_d;
  logic [CHBIT-1:0] last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       limit;
  logic             rdvalid_q;
  logic [CHBIT-1:0] rdsel_q;
  logic [NCH-1:0]   eligible;
  logic             grant_found;
  logic [CHBIT-1:0] grant_ch;
  logic             rd;

`ifdef FIFO_RR_SCHED_WEIGHT_EN
  logic [7:0] limit_q, limit_d;

  // A zero-weight channel is treated as empty so it can never win a grant.
  always_comb begin
    for (int i = 0; i < NCH; i++)
      eligible[i] = bus.ch_notempty[i] && (bus.ch_weight[i*WBIT +: WBIT] != '0);
  end

  assign limit = limit_q;
`else
  assign eligible = bus.ch_notempty;
  assign limit    = 8'(BURST);
`endif

  // Walk downward so the nearest channel after last_q is written last and wins.
  always_comb begin
    logic [CHBIT-1:0] idx;
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = CHBIT'((int'(last_q) + k) % NCH);
      if (eligible[idx]) begin
        grant_found = 1'b1;
        grant_ch    = idx;
      end
    end
  end

  assign rd = (state_q == XFER) && bus.out_ready && bus.ch_notempty[sel_q];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d       = state_q;
    sel_d         = sel_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    bus.ch_fiford = '0;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
    limit_d       = limit_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.enable && grant_found) begin
          state_d = XFER;
          sel_d   = grant_ch;
          last_d  = grant_ch;
          cnt_d   = '0;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
          limit_d = 8'(bus.ch_weight[int'(grant_ch)*WBIT +: WBIT]);
`endif
        end
      end
      XFER: begin
        if (rd) begin
          bus.ch_fiford = NCH'(1) << sel_q;
          cnt_d         = cnt_q + 8'd1;
        end
        if ((rd && (cnt_q == limit - 8'd1)) || !bus.ch_notempty[sel_q] || !bus.enable)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= CHBIT'(NCH - 1);
      cnt_q     <= '0;
      rdvalid_q <= 1'b0;
      rdsel_q   <= '0;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
      limit_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rdvalid_q <= rd;
      rdsel_q   <= sel_q;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
      limit_q   <= limit_d;
`endif
    end
  end

  assign bus.sel     = sel_q;
  assign bus.rdvalid = rdvalid_q;
  assign bus.rdsel   = rdsel_q;
  assign bus.busy    = (state_q == XFER);

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched: vector table for round-robin order plus
// hand-written sequences for drain, stall, mid-burst reset, enable and weights.
module tb_fifo_rr_sched;
  localparam int NCH   = 4;
  localparam int CHBIT = 2;
  localparam int BURST = 4;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] ne;
    logic       rdy;
    logic [3:0] f;
    logic [1:0] sel;
    logic       rv;
    logic [1:0] rs;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   strobes[NCH];
  vec_t vecs[$];

  fifo_rr_sched_if #(.NCH(NCH), .CHBIT(CHBIT)) bus ();

  fifo_rr_sched #(.NCH(NCH), .CHBIT(CHBIT), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  // Drive inputs just after a rising edge, check at the falling edge.
  task automatic step(input logic r, input logic en, input logic [3:0] ne, input logic rdy,
                      input logic [3:0] ef, input logic [1:0] es, input logic ev,
                      input logic [1:0] ers, input logic eb, input string tag);
    rst             = r;
    bus.enable      = en;
    bus.ch_notempty = ne;
    bus.out_ready   = rdy;
    @(negedge clk);
    check({tag, ".fiford"},  32'(bus.ch_fiford), 32'(ef));
    check({tag, ".sel"},     32'(bus.sel),       32'(es));
    check({tag, ".rdvalid"}, 32'(bus.rdvalid),   32'(ev));
    check({tag, ".rdsel"},   32'(bus.rdsel),     32'(ers));
    check({tag, ".busy"},    32'(bus.busy),      32'(eb));
    for (int c = 0; c < NCH; c++)
      if (bus.ch_fiford[c]) strobes[c]++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    for (int c = 0; c < NCH; c++) strobes[c] = 0;
  endtask

  initial begin
    logic [1:0] prev_sel;
    rst             = 1'b1;
    bus.enable      = 1'b0;
    bus.ch_notempty = '0;
    bus.out_ready   = 1'b0;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
    bus.ch_weight   = {8'd4, 8'd4, 8'd4, 8'd4};
`endif
    clear_strobes();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then 10 idle cycles with nothing to read.
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0});
    // All channels full: order 0,1,2,3,0, each burst 4 strobes plus one idle bubble.
    prev_sel = 2'd0;
    for (int r = 0; r < 5; r++) begin
      logic [1:0] ch;
      ch = 2'(r % NCH);
      vecs.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, 4'b0000, prev_sel, (r > 0), prev_sel, 1'b0});
      for (int k = 0; k < BURST; k++)
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, 4'(1) << ch, ch, (k > 0),
                         (k == 0) ? prev_sel : ch, 1'b1});
      prev_sel = ch;
    end
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 1'b0});

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].en, vecs[i].ne, vecs[i].rdy, vecs[i].f, vecs[i].sel,
           vecs[i].rv, vecs[i].rs, vecs[i].busy, $sformatf("vec%0d", i));
    check("rr.ch0_strobes", 32'(strobes[0]), 32'd8);
    check("rr.ch3_strobes", 32'(strobes[3]), 32'd4);

    // Only ch2 holds two words: exactly two strobes, then back to idle for good.
    clear_strobes();
    step(0, 1, 4'b0100, 1, 4'b0000, 2'd0, 0, 2'd0, 0, "drain.idle");
    step(0, 1, 4'b0100, 1, 4'b0100, 2'd2, 0, 2'd0, 1, "drain.rd1");
    step(0, 1, 4'b0100, 1, 4'b0100, 2'd2, 1, 2'd2, 1, "drain.rd2");
    step(0, 1, 4'b0000, 1, 4'b0000, 2'd2, 1, 2'd2, 1, "drain.empty");
    step(0, 1, 4'b0000, 1, 4'b0000, 2'd2, 0, 2'd2, 0, "drain.idle2");
    step(0, 1, 4'b0000, 1, 4'b0000, 2'd2, 0, 2'd2, 0, "drain.idle3");
    check("drain.ch2_strobes", 32'(strobes[2]), 32'd2);

    // ch1 burst stalled by out_ready for 3 cycles still totals BURST reads.
    clear_strobes();
    step(0, 1, 4'b0010, 1, 4'b0000, 2'd2, 0, 2'd2, 0, "stall.idle");
    step(0, 1, 4'b0010, 1, 4'b0010, 2'd1, 0, 2'd2, 1, "stall.rd1");
    step(0, 1, 4'b0010, 1, 4'b0010, 2'd1, 1, 2'd1, 1, "stall.rd2");
    step(0, 1, 4'b0010, 0, 4'b0000, 2'd1, 1, 2'd1, 1, "stall.hold1");
    step(0, 1, 4'b0010, 0, 4'b0000, 2'd1, 0, 2'd1, 1, "stall.hold2");
    step(0, 1, 4'b0010, 0, 4'b0000, 2'd1, 0, 2'd1, 1, "stall.hold3");
    step(0, 1, 4'b0010, 1, 4'b0010, 2'd1, 0, 2'd1, 1, "stall.rd3");
    step(0, 1, 4'b0010, 1, 4'b0010, 2'd1, 1, 2'd1, 1, "stall.rd4");
    step(0, 1, 4'b0000, 1, 4'b0000, 2'd1, 1, 2'd1, 0, "stall.idle2");
    check("stall.ch1_strobes", 32'(strobes[1]), 32'd4);

    // Reset on the third read of a ch1 burst; next grant restarts at ch0.
    step(0, 1, 4'b0010, 1, 4'b0000, 2'd1, 0, 2'd1, 0, "rst.idle");
    step(0, 1, 4'b0010, 1, 4'b0010, 2'd1, 0, 2'd1, 1, "rst.rd1");
    step(0, 1, 4'b0010, 1, 4'b0010, 2'd1, 1, 2'd1, 1, "rst.rd2");
    step(1, 1, 4'b0010, 1, 4'b0010, 2'd1, 1, 2'd1, 1, "rst.rd3");
    step(0, 1, 4'b1111, 1, 4'b0000, 2'd0, 0, 2'd0, 0, "rst.after");
    step(0, 1, 4'b1111, 1, 4'b0001, 2'd0, 0, 2'd0, 1, "rst.grant0");
    step(0, 1, 4'b0000, 1, 4'b0000, 2'd0, 1, 2'd0, 1, "rst.empty");
    step(0, 1, 4'b0000, 1, 4'b0000, 2'd0, 0, 2'd0, 0, "rst.idle2");

    // Dropping enable ends the burst and blocks new grants.
    step(0, 1, 4'b1111, 1, 4'b0000, 2'd0, 0, 2'd0, 0, "en.idle");
    step(0, 1, 4'b1111, 1, 4'b0010, 2'd1, 0, 2'd0, 1, "en.rd1");
    step(0, 0, 4'b1111, 1, 4'b0010, 2'd1, 1, 2'd1, 1, "en.off");
    step(0, 0, 4'b1111, 1, 4'b0000, 2'd1, 1, 2'd1, 0, "en.hold1");
    step(0, 0, 4'b1111, 1, 4'b0000, 2'd1, 0, 2'd1, 0, "en.hold2");

`ifdef FIFO_RR_SCHED_WEIGHT_EN
    // Weights {1,0,3,2}: two full rounds take 18 cycles after reset.
    step(1, 0, 4'b1111, 1, 4'b0000, 2'd1, 0, 2'd1, 0, "wt.rst");
    bus.ch_weight = {8'd2, 8'd3, 8'd0, 8'd1};
    clear_strobes();
    rst             = 1'b0;
    bus.enable      = 1'b1;
    bus.ch_notempty = 4'b1111;
    bus.out_ready   = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++)
        if (bus.ch_fiford[c]) strobes[c]++;
      @(posedge clk);
      #1;
    end
    check("wt.ch0_reads", 32'(strobes[0]), 32'd2);
    check("wt.ch1_reads", 32'(strobes[1]), 32'd0);
    check("wt.ch2_reads", 32'(strobes[2]), 32'd6);
    check("wt.ch3_reads", 32'(strobes[3]), 32'd4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
